// File: rtl/filter_out_packer.sv
// filter_out_packer: blanks post-switch filter samples, buffers them and emits fixed-length AXI-Stream packets
module filter_out_packer #(
    parameter int DEPTH      = 16,
    parameter int PKT_LEN    = 32,
    parameter int SETTLE_LEN = 8,
    parameter int DROP_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    ctrl,
    input  logic [7:-6]             s_tdata,
    input  logic                    s_tvalid,
    output logic [7:-6]             m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
    output logic                    blanking,
    output logic                    overflow,
    output logic [DROP_CNT_W-1:0]   drop_cnt,
    output logic [$clog2(DEPTH):0]  level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(PKT_LEN);
    localparam int SW = $clog2(SETTLE_LEN + 1);
    typedef enum logic {RUN, BLANK} state_t;
    state_t                state_q, state_d;
    logic                  ctrl_q, ctrl_edge, pop, run_in, full, wr, drop;
    logic [SW-1:0]         settle_q, settle_d, settle_inc;
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]         level_q;
    logic [BW-1:0]         beat_q;
    logic                  overflow_q;
    logic [DROP_CNT_W-1:0] drop_q;
    logic [7:-6]           mem [DEPTH];
    always_comb begin
        ctrl_edge  = ctrl != ctrl_q;
        pop        = m_tvalid && m_tready;
        run_in     = s_tvalid && state_q == RUN && !ctrl_edge;
        full       = level_q == LW'(DEPTH);
        wr         = run_in && (!full || pop);
        drop       = run_in && full && !pop;
        settle_inc = settle_q + SW'(1);
        state_d    = ctrl_edge ? BLANK :
                     (state_q == BLANK && s_tvalid && settle_inc == SW'(SETTLE_LEN)) ? RUN : state_q;
        settle_d   = ctrl_edge ? '0 : (state_q == BLANK && s_tvalid) ? settle_inc : settle_q;
    end
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= RUN;
            ctrl_q     <= ctrl;
            settle_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            beat_q     <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl;
            settle_q <= settle_d;
            level_q  <= level_q + LW'(wr) - LW'(pop);
            if (wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (pop) beat_q <= m_tlast ? '0 : beat_q + BW'(1);
            if (drop) begin
                overflow_q <= 1'b1;
                drop_q     <= drop_q + DROP_CNT_W'(drop_q != '1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr_q] <= s_tdata;
    end
    assign m_tvalid = level_q != '0;
    assign m_tdata  = m_tvalid ? mem[rd_ptr_q] : '0;
    assign m_tlast  = m_tvalid && beat_q == BW'(PKT_LEN - 1);
    assign blanking = state_q == BLANK;
    assign overflow = overflow_q;
    assign drop_cnt = drop_q;
    assign level    = level_q;
endmodule

// File: tb/tb_filter_out_packer.sv
// tb_filter_out_packer: directed tests of blanking, buffering, framing and overflow counting
module tb_filter_out_packer;
    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic        ctrl = 1'b0;
    logic [7:-6] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic [7:-6] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;
    logic        blanking;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic [4:0]  level;
    int checks = 0;
    int errors = 0;

    filter_out_packer dut (
        .clk(clk), .srst(srst), .ctrl(ctrl), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .blanking(blanking), .overflow(overflow), .drop_cnt(drop_cnt), .level(level)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        srst = 1'b1;
        s_tvalid = 1'b0;
        tick();
        srst = 1'b0;
    endtask

    task automatic test_reset;
        srst = 1'b1;
        tick();
        tick();
        srst = 1'b0;
        checks++;
        if ({m_tvalid, m_tlast, blanking, overflow} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {m_tvalid, m_tlast, blanking, overflow});
        end
        checks++;
        if ({drop_cnt, level, m_tdata} !== 35'd0) begin
            errors++;
            $display("FAIL reset_counts drop=%0d level=%0d data=%h want 0", drop_cnt, level, m_tdata);
        end
    endtask

    task automatic test_stream;
        do_reset();
        m_tready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s_tdata = 14'(i << 6);
            s_tvalid = 1'b1;
            tick();
            checks++;
            if ({m_tvalid, m_tlast, m_tdata} !== {1'b1, 1'(i == 31), 14'(i << 6)}) begin
                errors++;
                $display("FAIL stream[%0d] got v=%b l=%b d=%h want v=1 l=%b d=%h", i, m_tvalid, m_tlast, m_tdata, i == 31, 14'(i << 6));
            end
        end
        s_tvalid = 1'b0;
        tick();
        checks++;
        if ({m_tvalid, level, drop_cnt} !== 22'd0) begin
            errors++;
            $display("FAIL stream_end got v=%b level=%0d drop=%0d want 0", m_tvalid, level, drop_cnt);
        end
    endtask

    task automatic test_overflow;
        do_reset();
        m_tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            s_tdata = 14'(100 + i);
            s_tvalid = 1'b1;
            tick();
        end
        s_tvalid = 1'b0;
        checks++;
        if ({m_tvalid, overflow, level, drop_cnt} !== {1'b1, 1'b1, 5'd16, 16'd4}) begin
            errors++;
            $display("FAIL ovf_state got v=%b ovf=%b level=%0d drop=%0d want 1 1 16 4", m_tvalid, overflow, level, drop_cnt);
        end
        m_tready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if ({m_tvalid, m_tdata} !== {1'b1, 14'(100 + k)}) begin
                errors++;
                $display("FAIL ovf_drain[%0d] got v=%b d=%0d want v=1 d=%0d", k, m_tvalid, m_tdata, 100 + k);
            end
            tick();
        end
        checks++;
        if ({m_tvalid, level} !== 6'd0) begin
            errors++;
            $display("FAIL ovf_empty got v=%b level=%0d want 0", m_tvalid, level);
        end
    endtask

    task automatic test_full_simul;
        do_reset();
        m_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_tdata = 14'(200 + i);
            s_tvalid = 1'b1;
            tick();
        end
        m_tready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            s_tdata = 14'(300 + k);
            s_tvalid = 1'b1;
            checks++;
            if ({level, m_tdata} !== {5'd16, 14'(200 + k)}) begin
                errors++;
                $display("FAIL full_simul[%0d] got level=%0d d=%0d want 16 %0d", k, level, m_tdata, 200 + k);
            end
            tick();
        end
        s_tvalid = 1'b0;
        checks++;
        if ({level, drop_cnt, overflow} !== {5'd16, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL full_simul_nodrop got level=%0d drop=%0d ovf=%b want 16 0 0", level, drop_cnt, overflow);
        end
        for (int j = 0; j < 16; j++) begin
            checks++;
            if ({m_tvalid, m_tdata} !== {1'b1, (j < 6) ? 14'(210 + j) : 14'(294 + j)}) begin
                errors++;
                $display("FAIL full_drain[%0d] got v=%b d=%0d want v=1 d=%0d", j, m_tvalid, m_tdata, (j < 6) ? 210 + j : 294 + j);
            end
            tick();
        end
    endtask

    task automatic test_blank;
        ctrl = 1'b0;
        do_reset();
        m_tready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_tdata = 14'(400 + i);
            s_tvalid = 1'b1;
            tick();
        end
        checks++;
        if ({m_tvalid, m_tdata} !== {1'b1, 14'd401}) begin
            errors++;
            $display("FAIL blank_pre got v=%b d=%0d want v=1 d=401", m_tvalid, m_tdata);
        end
        s_tvalid = 1'b0;
        ctrl = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (blanking !== 1'(i < 8)) begin
                errors++;
                $display("FAIL blank_flag[%0d] got %b want %b", i, blanking, i < 8);
            end
            s_tdata = 14'(500 + i);
            s_tvalid = 1'b1;
            tick();
            checks++;
            if ({m_tvalid, m_tdata} !== ((i < 8) ? 15'd0 : {1'b1, 14'(500 + i)})) begin
                errors++;
                $display("FAIL blank_out[%0d] got v=%b d=%0d want v=%b d=%0d", i, m_tvalid, m_tdata, i >= 8, (i < 8) ? 0 : 500 + i);
            end
        end
        s_tvalid = 1'b0;
        checks++;
        if ({drop_cnt, overflow} !== 17'd0) begin
            errors++;
            $display("FAIL blank_drop got drop=%0d ovf=%b want 0 0", drop_cnt, overflow);
        end
    endtask

    task automatic test_restart;
        do_reset();
        m_tready = 1'b1;
        checks++;
        if (blanking !== 1'b0) begin
            errors++;
            $display("FAIL restart_reset_blank got %b want 0", blanking);
        end
        ctrl = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            s_tdata = 14'(650 + i);
            s_tvalid = 1'b1;
            tick();
        end
        s_tvalid = 1'b0;
        ctrl = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (blanking !== 1'(i < 8)) begin
                errors++;
                $display("FAIL restart_flag[%0d] got %b want %b", i, blanking, i < 8);
            end
            s_tdata = 14'(600 + i);
            s_tvalid = 1'b1;
            tick();
            checks++;
            if ({m_tvalid, m_tdata} !== ((i < 8) ? 15'd0 : {1'b1, 14'(600 + i)})) begin
                errors++;
                $display("FAIL restart_out[%0d] got v=%b d=%0d want v=%b d=%0d", i, m_tvalid, m_tdata, i >= 8, (i < 8) ? 0 : 600 + i);
            end
        end
        s_tvalid = 1'b0;
        tick();
        checks++;
        if ({drop_cnt, m_tvalid} !== 17'd0) begin
            errors++;
            $display("FAIL restart_end got drop=%0d v=%b want 0 0", drop_cnt, m_tvalid);
        end
    endtask

    task automatic test_srst_mid;
        do_reset();
        m_tready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_tdata = 14'(i);
            s_tvalid = 1'b1;
            tick();
        end
        s_tvalid = 1'b0;
        tick();
        m_tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            s_tdata = 14'(700 + i);
            s_tvalid = 1'b1;
            tick();
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        m_tready = 1'b0;
        checks++;
        if ({level, overflow, drop_cnt, m_tdata} !== {5'd5, 1'b1, 16'd4, 14'd711}) begin
            errors++;
            $display("FAIL srst_pre got level=%0d ovf=%b drop=%0d d=%0d want 5 1 4 711", level, overflow, drop_cnt, m_tdata);
        end
        do_reset();
        checks++;
        if ({m_tvalid, level, overflow, drop_cnt, blanking} !== 24'd0) begin
            errors++;
            $display("FAIL srst_clear got v=%b level=%0d ovf=%b drop=%0d blank=%b want 0", m_tvalid, level, overflow, drop_cnt, blanking);
        end
        m_tready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            s_tdata = 14'(800 + i);
            s_tvalid = 1'b1;
            tick();
            checks++;
            if ({m_tvalid, m_tlast, m_tdata} !== {1'b1, 1'(i == 31), 14'(800 + i)}) begin
                errors++;
                $display("FAIL srst_pkt[%0d] got v=%b l=%b d=%0d want v=1 l=%b d=%0d", i, m_tvalid, m_tlast, m_tdata, i == 31, 800 + i);
            end
        end
        s_tvalid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_overflow();
        test_full_simul();
        test_blank();
        test_restart();
        test_srst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
